// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operation request, result return, FSM debug state.
// Valid/ready: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers where out_valid && out_ready; producers hold data stable until then.
interface alu_seq_if #(
  parameter int W    = 8,
  parameter int IMMW = 2,
  parameter int SHW  = $clog2(W)
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alu_cmd;
  logic            direct;
  logic [IMMW-1:0] immed;
  logic [SHW-1:0]  shamt;
  logic [W-1:0]    inA;
  logic [W-1:0]    inB;
  logic            sc_i;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    rslt;
  logic            sc_o;
  logic            pari;
  logic            zero;
  logic            br_logic;
  logic [1:0]      fsm_state;

  modport master (
    output in_valid, alu_cmd, direct, immed, shamt, inA, inB, sc_i, out_ready,
    input  in_ready, out_valid, rslt, sc_o, pari, zero, br_logic, fsm_state
  );

  modport slave (
    input  in_valid, alu_cmd, direct, immed, shamt, inA, inB, sc_i, out_ready,
    output in_ready, out_valid, rslt, sc_o, pari, zero, br_logic, fsm_state
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic ops, bit-serial shifts, optional
// shift-add multiply on opcode 111 when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int W    = 8,
  parameter int IMMW = 2,
  parameter int SHW  = $clog2(W)
) (
  input logic   clk,
  input logic   rst_n,
  alu_seq_if.slave bus
);
  localparam logic [2:0] OP_LDR   = 3'b000;
  localparam logic [2:0] OP_STR   = 3'b001;
  localparam logic [2:0] OP_MOV   = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b101;
  localparam logic [2:0] OP_CMP   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  logic [2:0]     cmd_r;
  logic           dir_r;
  logic           sc_in_r;
  logic [W-1:0]   work;
  logic [SHW-1:0] sh_cnt;
  logic [W-1:0]   rslt_q;
  logic           sc_q;
  logic           pari_q;
  logic           zero_q;
  logic           br_q;

`ifdef ALU_SEQ_MUL_EN
  localparam int MCW = $clog2(W + 1);
  localparam logic [MCW-1:0] MUL_ITERS = MCW'(W);
  logic [MCW-1:0] mul_cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] acc_next;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  logic [W-1:0] quick_rslt;
  logic         quick_br;
  logic [W-1:0] sh_next;
  logic         sh_out;
  logic         go_busy;
  logic         last_step;
  logic         load;
  logic [W-1:0] fin_rslt;
  logic         fin_sc;
  logic         fin_br;

  // Results of ops that finish on the accept edge, straight from the request.
  always_comb begin
    quick_rslt = '0;
    quick_br   = 1'b0;
    case (bus.alu_cmd)
      OP_LDR, OP_STR: quick_rslt = bus.inA;
      OP_MOV:         quick_rslt[IMMW-1:0] = bus.immed;
      OP_XOR:         quick_rslt = bus.inA ^ bus.inB;
      OP_AND:         quick_rslt = bus.inA & bus.inB;
      OP_SHIFT:       quick_rslt = bus.inA;
      OP_CMP:         quick_br   = (bus.inA == bus.inB);
      OP_MUL:         quick_rslt = '0;
      default:        quick_rslt = '0;
    endcase
  end

  always_comb begin
    if (dir_r) begin
      sh_next = {sc_in_r, work[W-1:1]};
      sh_out  = work[0];
    end else begin
      sh_next = {work[W-2:0], sc_in_r};
      sh_out  = work[W-1];
    end
  end

  always_comb begin
    go_busy   = (bus.alu_cmd == OP_SHIFT) && (bus.shamt != '0);
    last_step = (state == S_BUSY) && (cmd_r == OP_SHIFT) && (sh_cnt == SHW'(1));
`ifdef ALU_SEQ_MUL_EN
    go_busy   = go_busy || (bus.alu_cmd == OP_MUL);
    last_step = last_step || ((state == S_BUSY) && (cmd_r == OP_MUL) && (mul_cnt == MCW'(1)));
`endif
    load = ((state == S_IDLE) && bus.in_valid && !go_busy) || last_step;
  end

  always_comb begin
    fin_rslt = quick_rslt;
    fin_sc   = 1'b0;
    fin_br   = quick_br;
    if (state == S_BUSY) begin
      fin_br = 1'b0;
      if (cmd_r == OP_SHIFT) begin
        fin_rslt = sh_next;
        fin_sc   = sh_out;
      end
`ifdef ALU_SEQ_MUL_EN
      else begin
        fin_rslt = acc_next[W-1:0];
        fin_sc   = |acc_next[2*W-1:W];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cmd_r   <= OP_LDR;
      dir_r   <= 1'b0;
      sc_in_r <= 1'b0;
      work    <= '0;
      sh_cnt  <= '0;
      rslt_q  <= '0;
      sc_q    <= 1'b0;
      pari_q  <= 1'b0;
      zero_q  <= 1'b0;
      br_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mul_cnt <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            cmd_r   <= bus.alu_cmd;
            dir_r   <= bus.direct;
            sc_in_r <= bus.sc_i;
            work    <= bus.inA;
            sh_cnt  <= bus.shamt;
`ifdef ALU_SEQ_MUL_EN
            mul_cnt <= MUL_ITERS;
            acc     <= '0;
            mcand   <= {{W{1'b0}}, bus.inA};
            mplier  <= bus.inB;
`endif
            state   <= go_busy ? S_BUSY : S_DONE;
          end
        end
        S_BUSY: begin
          if (cmd_r == OP_SHIFT) begin
            work   <= sh_next;
            sh_cnt <= sh_cnt - SHW'(1);
          end
`ifdef ALU_SEQ_MUL_EN
          else begin
            acc     <= acc_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt - MCW'(1);
          end
`endif
          if (last_step) state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Flags are derived from the same value that lands in rslt.
      if (load) begin
        rslt_q <= fin_rslt;
        sc_q   <= fin_sc;
        pari_q <= ^fin_rslt;
        zero_q <= (fin_rslt == '0);
        br_q   <= fin_br;
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.rslt      = rslt_q;
  assign bus.sc_o      = sc_q;
  assign bus.pari      = pari_q;
  assign bus.zero      = zero_q;
  assign bus.br_logic  = br_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios then randomized ops,
// each compared with a behavioural model of the opcode rules.
module tb_alu_seq;
  localparam int W    = 8;
  localparam int IMMW = 2;
  localparam int SHW  = $clog2(W);

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  alu_seq_if #(.W(W), .IMMW(IMMW)) bus ();

  alu_seq #(.W(W), .IMMW(IMMW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] rslt;
    logic         sc;
    logic         pari;
    logic         zero;
    logic         br;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [2:0] cmd, input logic dir,
                                 input logic [IMMW-1:0] imm, input logic [SHW-1:0] sh,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input logic sci);
    exp_t           e;
    logic [2*W-1:0] t;
    logic [W-1:0]   fill;
    int             n;
    e = '0;
    n = int'(sh);
    case (cmd)
      3'd0, 3'd1: e.rslt = a;
      3'd2:       e.rslt = W'(imm);
      3'd3:       e.rslt = a ^ b;
      3'd4:       e.rslt = a & b;
      3'd5: begin
        if (n == 0) e.rslt = a;
        else if (!dir) begin
          t      = {{W{1'b0}}, a} << n;
          fill   = sci ? W'((1 << n) - 1) : '0;
          e.rslt = t[W-1:0] | fill;
          e.sc   = t[W];
        end else begin
          t      = {a, {W{1'b0}}} >> n;
          fill   = sci ? ~({W{1'b1}} >> n) : '0;
          e.rslt = t[2*W-1:W] | fill;
          e.sc   = t[W-1];
        end
      end
      3'd6: e.br = (a == b);
      default: begin
`ifdef ALU_SEQ_MUL_EN
        t      = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.rslt = t[W-1:0];
        e.sc   = |t[2*W-1:W];
`else
        e.rslt = '0;
`endif
      end
    endcase
    e.pari = ^e.rslt;
    e.zero = (e.rslt == '0);
    return e;
  endfunction

  function automatic int latency(input logic [2:0] cmd, input logic [SHW-1:0] sh);
    if (cmd == 3'd5 && sh != '0) return 1 + int'(sh);
`ifdef ALU_SEQ_MUL_EN
    if (cmd == 3'd7) return W + 1;
`endif
    return 1;
  endfunction

  // Called at a falling edge; returns at the falling edge one cycle after accept.
  task automatic start_op(input logic [2:0] cmd, input logic dir, input logic [IMMW-1:0] imm,
                          input logic [SHW-1:0] sh, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic sci);
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_before_issue", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.alu_cmd  = cmd;
    bus.direct   = dir;
    bus.immed    = imm;
    bus.shamt    = sh;
    bus.inA      = a;
    bus.inB      = b;
    bus.sc_i     = sci;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, "_out_valid"}, bus.out_valid, 1);
    check({tag, "_rslt"}, bus.rslt, e.rslt);
    check({tag, "_sc_o"}, bus.sc_o, e.sc);
    check({tag, "_pari"}, bus.pari, e.pari);
    check({tag, "_zero"}, bus.zero, e.zero);
    check({tag, "_br_logic"}, bus.br_logic, e.br);
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_in_ready_after_drain"}, bus.in_ready, 1);
    check({tag, "_out_valid_after_drain"}, bus.out_valid, 0);
  endtask

  task automatic run(input string tag, input logic [2:0] cmd, input logic dir,
                     input logic [IMMW-1:0] imm, input logic [SHW-1:0] sh,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic sci);
    start_op(cmd, dir, imm, sh, a, b, sci);
    wait_done(tag, latency(cmd, sh));
    check_out(tag, model(cmd, dir, imm, sh, a, b, sci));
    drain(tag);
  endtask

  initial begin
    logic [2:0]      r_cmd;
    logic            r_dir;
    logic [IMMW-1:0] r_imm;
    logic [SHW-1:0]  r_sh;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sci;

    bus.in_valid  = 1'b0;
    bus.alu_cmd   = '0;
    bus.direct    = 1'b0;
    bus.immed     = '0;
    bus.shamt     = '0;
    bus.inA       = '0;
    bus.inB       = '0;
    bus.sc_i      = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_rslt", bus.rslt, 0);
    check("reset_sc_o", bus.sc_o, 0);
    check("reset_pari", bus.pari, 0);
    check("reset_zero", bus.zero, 0);
    check("reset_br_logic", bus.br_logic, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("xor", 3'd3, 1'b0, 2'd0, 3'd0, 8'hA5, 8'h0F, 1'b0);
    check("xor_const_rslt", bus.rslt, 8'hAA);
    run("shl3", 3'd5, 1'b0, 2'd0, 3'd3, 8'h81, 8'h00, 1'b0);
    check("shl3_const_rslt", bus.rslt, 8'h08);
    run("shr1", 3'd5, 1'b1, 2'd0, 3'd1, 8'h81, 8'h00, 1'b1);
    check("shr1_const_rslt", bus.rslt, 8'hC0);
    check("shr1_const_sc", bus.sc_o, 1);
    run("sh0", 3'd5, 1'b1, 2'd0, 3'd0, 8'h5A, 8'h00, 1'b1);
    run("shl7_fill", 3'd5, 1'b0, 2'd0, 3'd7, 8'h93, 8'h00, 1'b1);
    run("cmp_eq", 3'd6, 1'b0, 2'd0, 3'd0, 8'h3C, 8'h3C, 1'b0);
    check("cmp_eq_const_br", bus.br_logic, 1);
    run("cmp_ne", 3'd6, 1'b0, 2'd0, 3'd0, 8'h3C, 8'h3D, 1'b0);
    run("str", 3'd1, 1'b0, 2'd0, 3'd0, 8'hE7, 8'h11, 1'b1);
    run("and", 3'd4, 1'b0, 2'd0, 3'd0, 8'hF0, 8'h3C, 1'b0);

    // Backpressure: result and handshake state must freeze while out_ready is low.
    start_op(3'd2, 1'b0, 2'b11, 3'd0, 8'h00, 8'h00, 1'b0);
    wait_done("mov_bp", 1);
    check("mov_bp_rslt", bus.rslt, 8'h03);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.alu_cmd  = 3'd3;
      bus.inA      = 8'hFF;
      bus.inB      = 8'h01;
      @(negedge clk);
      check("bp_hold_rslt", bus.rslt, 8'h03);
      check("bp_hold_out_valid", bus.out_valid, 1);
      check("bp_hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    drain("mov_bp");

    // Reset three cycles into a long shift aborts it with no output.
    start_op(3'd5, 1'b0, 2'd0, 3'd7, 8'h81, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_rslt", bus.rslt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_output", bus.out_valid, 0);
    run("ldr_after_reset", 3'd0, 1'b0, 2'd0, 3'd0, 8'h55, 8'h00, 1'b0);
    check("ldr_const_rslt", bus.rslt, 8'h55);
    check("ldr_const_pari", bus.pari, 0);

`ifdef ALU_SEQ_MUL_EN
    run("mul_small", 3'd7, 1'b0, 2'd0, 3'd0, 8'h0D, 8'h0B, 1'b0);
    check("mul_small_const_rslt", bus.rslt, 8'h8F);
    run("mul_ovf", 3'd7, 1'b0, 2'd0, 3'd0, 8'h20, 8'h10, 1'b0);
    check("mul_ovf_const_sc", bus.sc_o, 1);
    check("mul_ovf_const_zero", bus.zero, 1);
    run("mul_max", 3'd7, 1'b0, 2'd0, 3'd0, 8'hFF, 8'hFF, 1'b0);
`else
    run("op7_nop", 3'd7, 1'b1, 2'd3, 3'd5, 8'h12, 8'h34, 1'b1);
    check("op7_const_zero", bus.zero, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      r_cmd = 3'($urandom_range(0, 7));
      r_dir = 1'($urandom_range(0, 1));
      r_imm = IMMW'($urandom_range(0, (1 << IMMW) - 1));
      r_sh  = SHW'($urandom_range(0, W - 1));
      r_a   = W'($urandom);
      r_b   = (i % 4 == 0) ? r_a : W'($urandom);
      r_sci = 1'($urandom_range(0, 1));
      run("rand", r_cmd, r_dir, r_imm, r_sh, r_a, r_b, r_sci);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked sequential ALU; the successor to the single-cycle combinational ALU. It accepts one operation per valid/ready transaction and runs shifts bit-serially, one bit per cycle. It optionally runs a shift-add multiply and returns a registered result with carry, parity, zero and branch flags. It sits between decode/register-file read and the writeback stage.

## Interface
Parameters:
- `W`, 8, data path width (≥4).
- `IMMW`, 2, immediate width (≤W).
- `SHW`, $clog2(W), shift-amount width (derived).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `alu_cmd`  in  3  opcode.
- `direct`  in  1  shift direction: 1 = right, 0 = left.
- `immed`  in  IMMW  immediate for MOV.
- `shamt`  in  SHW  shift amount.
- `inA`, `inB`  in  W  operands.
- `sc_i`  in  1  shift carry in.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `rslt`  out  W  result.
- `sc_o`  out  1  shift carry out / multiply overflow.
- `pari`  out  1  XOR reduction of `rslt`.
- `zero`  out  1  `rslt` == 0.
- `br_logic`  out  1  CMP equal.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- In IDLE, `in_valid` captures all inputs into internal registers.
- Single-cycle ops (000–100, 110, and 111 without the multiply feature) go to DONE.
- SHIFT with `shamt` ≠ 0, and MUL, go to BUSY. SHIFT with `shamt` = 0 goes to DONE with `rslt` = A and `sc_o` = 0.
- BUSY decrements a counter each cycle and goes to DONE when the count reaches 0.
- In DONE, `out_valid` = 1. `out_ready` returns the FSM to IDLE.
- There is no accept-on-same-cycle-as-drain; the minimum spacing between operations is 2 cycles.
- Opcodes:
  - 000 LDR: `rslt` = A.
  - 001 STR: `rslt` = A.
  - 010 MOV: `rslt` = zero-extended `immed`.
  - 011 XOR: `rslt` = A ^ B.
  - 100 AND: `rslt` = A & B.
  - 101 SHIFT: left step `r` = {r[W-2:0], sc_i}, `sc_o` = old r[W-1]. Right step `r` = {sc_i, r[W-1:1]}, `sc_o` = old r[0]. The final `sc_o` is the last bit shifted out.
  - 110 CMP: `br_logic` = (A == B), `rslt` = 0.
  - 111: MUL, see Configuration.
- `br_logic` is 0 for every op except CMP. `sc_o` is 0 except on SHIFT and MUL.
- `zero` and `pari` are computed from the final `rslt` and registered with it.
- While `out_valid` = 1 and `out_ready` = 0, all outputs hold stable and `in_valid` is ignored.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `rslt` 0, `sc_o` 0, `pari` 0, `zero` 0, `br_logic` 0.
- Reset is honoured in any state. Asserting reset mid-BUSY aborts the op with no output. `in_ready` = 1 and `out_valid` = 0 while `rst_n` is low.
- Latency is counted from the accept edge to `out_valid` high:
  - single-cycle ops: 1 cycle.
  - SHIFT: 1 + `shamt` cycles.
  - MUL: W + 1 cycles.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from any input.
- Counter and width rules:
  - the SHIFT counter is SHW bits;
  - the MUL counter is `$clog2(W+1)` bits;
  - the MUL accumulator is 2W bits and never wraps.

## Configuration
- Macro `ALU_SEQ_MUL_EN`.
- Defined: opcode 111 is an unsigned shift-add multiply over W iterations.
  - `rslt` = product[W-1:0].
  - `sc_o` = |product[2W-1:W] (overflow).
  - The flags follow `rslt`.
- Undefined: opcode 111 is a single-cycle no-op with `rslt` = 0 and all flags cleared except `zero` = 1. No multiplier or accumulator logic is synthesised.

## Test plan
- XOR, A=0xA5 B=0x0F, W=8 -> `out_valid` 1 cycle after accept; `rslt` 0xAA, `pari` 0, `zero` 0, `sc_o` 0, `br_logic` 0.
- SHIFT:
  - left, A=0x81, `shamt`=3, `sc_i`=0 -> `out_valid` 4 cycles after accept; `rslt` 0x08, `sc_o` 0.
  - right, A=0x81, `shamt`=1, `sc_i`=1 -> `out_valid` 2 cycles after accept; `rslt` 0xC0, `sc_o` 1.
  - `shamt`=0 -> latency 1 and `rslt` = A.
- CMP, A=B=0x3C -> `br_logic` 1, `rslt` 0x00, `zero` 1. Then A=0x3C B=0x3D -> `br_logic` 0.
- Backpressure: hold `out_ready`=0 for 5 cycles after a MOV with `immed`=2'b11 -> `rslt` stays 0x03, `out_valid` stays 1, `in_ready` stays 0, and new `in_valid` pulses are ignored. Raising `out_ready` gives `in_ready` = 1 on the next cycle.
- Reset: drop `rst_n` 3 cycles into a SHIFT with `shamt`=7 -> `out_valid` 0 and `in_ready` 1 immediately. After release, a following LDR A=0x55 completes normally with `rslt` 0x55 and `pari` 0.
- MUL with `ALU_SEQ_MUL_EN` defined:
  - 0x0D × 0x0B -> `rslt` 0x8F, `sc_o` 0, after 9 cycles.
  - 0x20 × 0x10 -> `rslt` 0x00, `sc_o` 1, `zero` 1.
- Opcode 111 with `ALU_SEQ_MUL_EN` undefined -> latency 1, `rslt` 0x00, `zero` 1.
